// File: rtl/chain_match_detect_if.sv
// chain_match_detect_if: request/result bundle of the ball-chain match stage.
// master drives Start/Insert_Idx/Path_Color; slave returns status and result.
interface chain_match_detect_if #(
    parameter int N_SLOTS = 26,
    parameter int COLOR_W = 4,
    parameter int SCORE_W = 16
);
    logic                              Start;
    logic [4:0]                        Insert_Idx;
    logic [N_SLOTS-1:0][COLOR_W-1:0]   Path_Color;
    logic                              Busy;
    logic                              Done;
    logic                              Match;
    logic [N_SLOTS-1:0]                Clear_Mask;
    logic [4:0]                        Run_Lo;
    logic [4:0]                        Run_Hi;
    logic [SCORE_W-1:0]                Score;

    modport master (
        output Start, Insert_Idx, Path_Color,
        input  Busy, Done, Match, Clear_Mask, Run_Lo, Run_Hi, Score
    );

    modport slave (
        input  Start, Insert_Idx, Path_Color,
        output Busy, Done, Match, Clear_Mask, Run_Lo, Run_Hi, Score
    );
endinterface

// File: rtl/chain_match_detect.sv
// chain_match_detect: snapshots the path colours, scans out from the insert
// slot one slot per cycle, reports the equal-colour run and a clear mask.
// Ports: Clk, Reset (sync, active-high); bus = chain_match_detect_if.slave.
module chain_match_detect #(
    parameter int N_SLOTS = 26,
    parameter int COLOR_W = 4,
    parameter int MIN_RUN = 3,
    parameter int SCORE_W = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    chain_match_detect_if.slave  bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEFT  = 3'd1;
    localparam logic [2:0] ST_RIGHT = 3'd2;
    localparam logic [2:0] ST_EVAL  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [4:0]         LAST_IDX = 5'(N_SLOTS - 1);
    localparam logic [4:0]         MIN_LEN  = 5'(MIN_RUN);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [2:0]                        r_state;
    logic [N_SLOTS-1:0][COLOR_W-1:0]   r_snap;
    logic [COLOR_W-1:0]                r_target;
    logic [4:0]                        r_lo;
    logic [4:0]                        r_hi;
    logic                              r_inv;
    logic                              r_match;
    logic [N_SLOTS-1:0]                r_mask;
    logic [4:0]                        r_run_lo;
    logic [4:0]                        r_run_hi;
    logic [SCORE_W-1:0]                r_score;

    logic                              w_in_range;
    logic [COLOR_W-1:0]                w_tgt;
    logic                              w_valid;
    logic [COLOR_W-1:0]                w_left;
    logic [COLOR_W-1:0]                w_right;
    logic                              w_left_stop;
    logic                              w_right_stop;
    logic [4:0]                        w_len;
    logic [SCORE_W:0]                  w_sum;
    logic [SCORE_W-1:0]                w_score_nxt;
    logic [N_SLOTS-1:0]                w_mask;

    // Out-of-range insert index must never reach the colour mux.
    assign w_in_range = (bus.Insert_Idx <= LAST_IDX);
    assign w_tgt      = w_in_range ? bus.Path_Color[bus.Insert_Idx] : '0;
    assign w_valid    = w_in_range && (w_tgt != '0);

    // Target is never 0, so an empty neighbour always ends the run.
    assign w_left  = (r_lo == 5'd0) ? '0 : r_snap[r_lo - 5'd1];
    assign w_right = (r_hi == LAST_IDX) ? '0 : r_snap[r_hi + 5'd1];

    assign w_left_stop  = (r_lo == 5'd0) || (w_left != r_target);
    assign w_right_stop = (r_hi == LAST_IDX) || (w_right != r_target);

    assign w_len = r_hi - r_lo + 5'd1;

    assign w_sum       = {1'b0, r_score} + (SCORE_W+1)'(w_len);
    assign w_score_nxt = w_sum[SCORE_W] ? SCORE_MAX : w_sum[SCORE_W-1:0];

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_mask[i] = (5'(i) >= r_lo) && (5'(i) <= r_hi);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_snap   <= '0;
            r_target <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_inv    <= 1'b0;
            r_match  <= 1'b0;
            r_mask   <= '0;
            r_run_lo <= '0;
            r_run_hi <= '0;
            r_score  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        r_snap   <= bus.Path_Color;
                        r_target <= w_tgt;
                        r_lo     <= bus.Insert_Idx;
                        r_hi     <= bus.Insert_Idx;
                        r_inv    <= !w_valid;
                        r_match  <= 1'b0;
                        r_mask   <= '0;
                        r_run_lo <= '0;
                        r_run_hi <= '0;
                        // Invalid target passes through EVAL without
                        // touching the results, giving Done one cycle on.
                        r_state  <= w_valid ? ST_LEFT : ST_EVAL;
                    end
                end
                ST_LEFT: begin
                    if (w_left_stop) begin
                        r_state <= ST_RIGHT;
                    end else begin
                        r_lo <= r_lo - 5'd1;
                    end
                end
                ST_RIGHT: begin
                    if (w_right_stop) begin
                        r_state <= ST_EVAL;
                    end else begin
                        r_hi <= r_hi + 5'd1;
                    end
                end
                ST_EVAL: begin
                    if (!r_inv) begin
                        r_run_lo <= r_lo;
                        r_run_hi <= r_hi;
                        if (w_len >= MIN_LEN) begin
                            r_match <= 1'b1;
                            r_mask  <= w_mask;
                            r_score <= w_score_nxt;
                        end
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy       = (r_state != ST_IDLE);
    assign bus.Done       = (r_state == ST_DONE);
    assign bus.Match      = r_match;
    assign bus.Clear_Mask = r_mask;
    assign bus.Run_Lo     = r_run_lo;
    assign bus.Run_Hi     = r_run_hi;
    assign bus.Score      = r_score;

endmodule

// File: tb/tb_chain_match_detect.sv
// tb_chain_match_detect: directed and randomized scenarios for
// chain_match_detect, checked against a run-finding reference model.
module tb_chain_match_detect;

    localparam int N = 26;
    typedef logic [N-1:0][3:0] col_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    chain_match_detect_if #(.N_SLOTS(N), .COLOR_W(4), .SCORE_W(16)) bus ();

    chain_match_detect #(
        .N_SLOTS(N), .COLOR_W(4), .MIN_RUN(3), .SCORE_W(16)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int m_score = 0;

    // Reference: walk outward from idx over equal non-empty colours.
    function automatic void model(input col_t c, input int idx,
                                  output bit valid, output int lo,
                                  output int hi);
        valid = (idx < N) && (c[idx] != 4'd0);
        lo = 0;
        hi = 0;
        if (valid) begin
            lo = idx;
            hi = idx;
            while (lo > 0 && c[lo-1] == c[idx]) lo--;
            while (hi < N-1 && c[hi+1] == c[idx]) hi++;
        end
    endfunction

    function automatic logic [N-1:0] span_mask(input int lo, input int hi);
        longint m;
        m = (64'sd1 <<< (hi + 1)) - (64'sd1 <<< lo);
        return N'(m);
    endfunction

    function automatic int sat_add(input int s, input int n);
        return (s + n > 65535) ? 65535 : s + n;
    endfunction

    // Leaves the caller at the negedge of the cycle after the accept edge.
    task automatic start_scan(input col_t c, input int idx);
        @(negedge Clk);
        bus.Path_Color = c;
        bus.Insert_Idx = 5'(idx);
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.Done !== 1'b1 && lat < 60) begin
            @(negedge Clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        m_score = 0;
        n_cmp++;
        if ({bus.Busy, bus.Done, bus.Match} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 000",
                     {bus.Busy, bus.Done, bus.Match});
        end
        n_cmp++;
        if (bus.Clear_Mask !== '0 || bus.Run_Lo !== 5'd0 || bus.Run_Hi !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_result got mask=%h lo=%0d hi=%0d want 0",
                     bus.Clear_Mask, bus.Run_Lo, bus.Run_Hi);
        end
        n_cmp++;
        if (bus.Score !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_score got %0d want 0", bus.Score);
        end
    endtask

    task automatic test_reset_mid_scan();
        col_t c;
        int dones;
        for (int i = 0; i < N; i++) c[i] = 4'd2;
        start_scan(c, 13);
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        m_score = 0;
        n_cmp++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_busy got busy=%b done=%b want 0 0",
                     bus.Busy, bus.Done);
        end
        n_cmp++;
        if (bus.Score !== 16'd0 || bus.Match !== 1'b0 ||
            bus.Clear_Mask !== '0 || bus.Run_Lo !== 5'd0 || bus.Run_Hi !== 5'd0) begin
            n_fail++;
            $display("FAIL midreset_out got score=%0d m=%b mask=%h want 0",
                     bus.Score, bus.Match, bus.Clear_Mask);
        end
        dones = 0;
        repeat (40) begin
            @(negedge Clk);
            if (bus.Done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL midreset_nodone got %0d dones want 0", dones);
        end
    endtask

    task automatic test_isolated();
        col_t c;
        int lat;
        c = '0;
        c[10] = 4'd1;
        c[11] = 4'd3;
        c[12] = 4'd2;
        start_scan(c, 11);
        wait_done(lat);
        n_cmp++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL iso_latency got %0d want 3", lat);
        end
        n_cmp++;
        if (bus.Match !== 1'b0 || bus.Clear_Mask !== '0) begin
            n_fail++;
            $display("FAIL iso_match got m=%b mask=%h want 0 0",
                     bus.Match, bus.Clear_Mask);
        end
        n_cmp++;
        if (bus.Run_Lo !== 5'd11 || bus.Run_Hi !== 5'd11) begin
            n_fail++;
            $display("FAIL iso_bounds got %0d..%0d want 11..11",
                     bus.Run_Lo, bus.Run_Hi);
        end
        n_cmp++;
        if (bus.Score !== 16'(m_score)) begin
            n_fail++;
            $display("FAIL iso_score got %0d want %0d", bus.Score, m_score);
        end
        @(negedge Clk);
        n_cmp++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL iso_pulse got done=%b busy=%b want 0 0",
                     bus.Done, bus.Busy);
        end
    endtask

    task automatic test_triple();
        col_t c;
        int lat;
        c = '0;
        c[7] = 4'd1;
        c[8] = 4'd4;
        c[9] = 4'd4;
        c[10] = 4'd4;
        c[11] = 4'd1;
        start_scan(c, 9);
        wait_done(lat);
        m_score = sat_add(m_score, 3);
        n_cmp++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL triple_latency got %0d want 5", lat);
        end
        n_cmp++;
        if (bus.Match !== 1'b1 || bus.Clear_Mask !== 26'h0000700) begin
            n_fail++;
            $display("FAIL triple_mask got m=%b mask=%h want 1 0000700",
                     bus.Match, bus.Clear_Mask);
        end
        n_cmp++;
        if (bus.Run_Lo !== 5'd8 || bus.Run_Hi !== 5'd10 || bus.Score !== 16'd3) begin
            n_fail++;
            $display("FAIL triple_bounds got %0d..%0d score=%0d want 8..10 3",
                     bus.Run_Lo, bus.Run_Hi, bus.Score);
        end
    endtask

    task automatic test_boundary();
        col_t c;
        int lat;
        c = '0;
        for (int i = 0; i <= 4; i++) c[i] = 4'd5;
        c[5] = 4'd1;
        start_scan(c, 0);
        wait_done(lat);
        m_score = sat_add(m_score, 5);
        n_cmp++;
        if (lat != 7 || bus.Clear_Mask !== 26'h1F || bus.Score !== 16'(m_score)) begin
            n_fail++;
            $display("FAIL bound_left got lat=%0d mask=%h score=%0d want 7 1f %0d",
                     lat, bus.Clear_Mask, bus.Score, m_score);
        end
        c = '0;
        for (int i = 22; i <= 25; i++) c[i] = 4'd6;
        c[21] = 4'd2;
        start_scan(c, 25);
        wait_done(lat);
        m_score = sat_add(m_score, 4);
        n_cmp++;
        if (lat != 6 || bus.Clear_Mask !== 26'h3C00000 ||
            bus.Run_Lo !== 5'd22 || bus.Run_Hi !== 5'd25) begin
            n_fail++;
            $display("FAIL bound_right got lat=%0d mask=%h %0d..%0d want 6 3c00000 22..25",
                     lat, bus.Clear_Mask, bus.Run_Lo, bus.Run_Hi);
        end
        n_cmp++;
        if (bus.Score !== 16'(m_score)) begin
            n_fail++;
            $display("FAIL bound_score got %0d want %0d", bus.Score, m_score);
        end
    endtask

    task automatic test_invalid();
        col_t c;
        int lat;
        for (int i = 0; i < N; i++) c[i] = 4'd3;
        start_scan(c, 27);
        wait_done(lat);
        n_cmp++;
        if (lat != 1 || bus.Match !== 1'b0 || bus.Run_Lo !== 5'd0 ||
            bus.Run_Hi !== 5'd0 || bus.Clear_Mask !== '0) begin
            n_fail++;
            $display("FAIL inv_range got lat=%0d m=%b %0d..%0d want 1 0 0..0",
                     lat, bus.Match, bus.Run_Lo, bus.Run_Hi);
        end
        c[5] = 4'd0;
        start_scan(c, 5);
        wait_done(lat);
        n_cmp++;
        if (lat != 1 || bus.Match !== 1'b0 || bus.Run_Lo !== 5'd0 ||
            bus.Run_Hi !== 5'd0 || bus.Score !== 16'(m_score)) begin
            n_fail++;
            $display("FAIL inv_empty got lat=%0d m=%b %0d..%0d score=%0d",
                     lat, bus.Match, bus.Run_Lo, bus.Run_Hi, bus.Score);
        end
    endtask

    task automatic test_isolation();
        col_t c;
        int lat;
        int dones;
        int hi_seen;
        c = '0;
        c[7] = 4'd1;
        c[8] = 4'd4;
        c[9] = 4'd4;
        c[10] = 4'd4;
        c[11] = 4'd1;
        start_scan(c, 9);
        bus.Path_Color[11] = 4'd4;
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        lat = -1;
        hi_seen = -1;
        dones = 0;
        for (int t = 1; t < 30; t++) begin
            if (bus.Done === 1'b1) begin
                dones++;
                if (lat < 0) begin
                    lat = t;
                    hi_seen = int'(bus.Run_Hi);
                end
            end
            @(negedge Clk);
        end
        m_score = sat_add(m_score, 3);
        n_cmp++;
        if (lat != 5 || hi_seen != 10) begin
            n_fail++;
            $display("FAIL snap_result got lat=%0d hi=%0d want 5 10", lat, hi_seen);
        end
        n_cmp++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL busy_start got %0d dones want 1", dones);
        end
        n_cmp++;
        if (bus.Score !== 16'(m_score)) begin
            n_fail++;
            $display("FAIL snap_score got %0d want %0d", bus.Score, m_score);
        end
    endtask

    task automatic test_random();
        col_t c;
        int idx, lat, lo, hi, len, e_lat;
        bit valid, e_match;
        logic [N-1:0] e_mask;
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N; i++) c[i] = 4'($urandom_range(0, 2));
            idx = $urandom_range(0, 27);
            model(c, idx, valid, lo, hi);
            len = hi - lo + 1;
            e_match = valid && (len >= 3);
            e_mask = e_match ? span_mask(lo, hi) : '0;
            e_lat = valid ? (hi - lo) + 3 : 1;
            if (e_match) m_score = sat_add(m_score, len);
            start_scan(c, idx);
            for (int i = 0; i < N; i++) bus.Path_Color[i] = 4'($urandom_range(0, 2));
            wait_done(lat);
            n_cmp++;
            if (lat != e_lat || bus.Match !== e_match || bus.Clear_Mask !== e_mask ||
                bus.Run_Lo !== 5'(lo) || bus.Run_Hi !== 5'(hi) ||
                bus.Score !== 16'(m_score)) begin
                n_fail++;
                $display("FAIL rand_%0d got lat=%0d m=%b mask=%h %0d..%0d sc=%0d want lat=%0d m=%b mask=%h %0d..%0d sc=%0d",
                         it, lat, bus.Match, bus.Clear_Mask, bus.Run_Lo, bus.Run_Hi,
                         bus.Score, e_lat, e_match, e_mask, lo, hi, m_score);
            end
        end
    endtask

    task automatic test_saturation();
        col_t c;
        int lat, r, len;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        m_score = 0;
        r = 65534;
        while (r > 0) begin
            if (r > 26) len = (r - 26 >= 3) ? 26 : r - 3;
            else len = r;
            c = '0;
            for (int i = 0; i < len; i++) c[i] = 4'd7;
            start_scan(c, 0);
            wait_done(lat);
            m_score = sat_add(m_score, len);
            r -= len;
        end
        n_cmp++;
        if (bus.Score !== 16'd65534) begin
            n_fail++;
            $display("FAIL sat_preload got %0d want 65534", bus.Score);
        end
        for (int k = 0; k < 2; k++) begin
            c = '0;
            for (int i = 3; i <= 5; i++) c[i] = 4'd9;
            start_scan(c, 4);
            wait_done(lat);
            m_score = sat_add(m_score, 3);
            n_cmp++;
            if (bus.Score !== 16'(m_score) || bus.Match !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_%0d got %0d m=%b want %0d 1",
                         k, bus.Score, bus.Match, m_score);
            end
        end
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.Insert_Idx = '0;
        bus.Path_Color = '0;
        test_reset();
        test_reset_mid_scan();
        test_isolated();
        test_triple();
        test_boundary();
        test_invalid();
        test_isolation();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
